// File: rtl/seg_pkg.sv
// Shared constants for the glyph-code scroller: glyph codes, widths and FSM state encoding.
package seg_pkg;

  localparam int unsigned CODE_W    = 4;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned LEN_W     = 5;
  localparam int unsigned MSG_DEPTH = 16;

  localparam logic [CODE_W-1:0] GLYPH_0     = 4'h0;
  localparam logic [CODE_W-1:0] GLYPH_1     = 4'h1;
  localparam logic [CODE_W-1:0] GLYPH_9     = 4'h9;
  localparam logic [CODE_W-1:0] GLYPH_BLANK = 4'hA;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/tick_div.sv
// Enable-gated modulo-DIV counter; tick is high on the terminal count while enabled.
module tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_msg_scroller.sv
// Scrolls a 16-entry glyph-code message across DIGITS multiplexed digits,
// emitting one code and an active-low digit select per scan slot.
module seg_msg_scroller
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned STEP_DIV = 25000000,
  parameter logic [3:0]  BLANK    = GLYPH_BLANK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [4:0]        msg_len,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [3:0]        wr_data,
  output logic [3:0]        X,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              wrap
);

  localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic [CODE_W-1:0] x_q, x_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              busy_q, busy_d;
  logic              wrap_q, wrap_d;
  logic [CODE_W-1:0] msg_q [MSG_DEPTH];

  logic              scan_tick;
  logic              step_tick;
  logic              len_ok_c;
  logic [LEN_W-1:0]  sum_c;
  logic [ADDR_W-1:0] idx_c;
  logic [CODE_W-1:0] code_c;

  tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .tick (scan_tick)
  );

  tick_div #(.DIV(STEP_DIV)) u_step_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .tick (step_tick)
  );

  assign len_ok_c = (msg_len != '0) && (msg_len <= LEN_W'(MSG_DEPTH));

  // Digit i shows entry (head+i) mod len; head<len and i<len keep one subtract sufficient.
  always_comb begin
    sum_c  = LEN_W'(head_q) + LEN_W'(dig_q);
    idx_c  = ADDR_W'((sum_c >= len_q) ? (sum_c - len_q) : sum_c);
    code_c = (LEN_W'(dig_q) >= len_q) ? BLANK : msg_q[idx_c];
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    head_d  = head_q;
    dig_d   = dig_q;
    wrap_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop && len_ok_c) begin
          state_d = ST_RUN;
          len_d   = msg_len;
          head_d  = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (scan_tick) begin
      dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
    end

    if (step_tick) begin
      if (head_q == ADDR_W'(len_q - LEN_W'(1))) begin
        head_d = '0;
        wrap_d = 1'b1;
      end else begin
        head_d = head_q + ADDR_W'(1);
      end
    end

    busy_d = (state_d != ST_IDLE);
    if (state_q == ST_IDLE) begin
      x_d  = BLANK;
      an_d = '1;
    end else begin
      x_d  = code_c;
      an_d = ~(DIGITS'(1) << dig_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      head_q  <= '0;
      dig_q   <= '0;
      x_q     <= BLANK;
      an_q    <= '1;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      head_q  <= head_d;
      dig_q   <= dig_d;
      x_q     <= x_d;
      an_q    <= an_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  // Register array rather than a RAM so every entry can reset to BLANK.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MSG_DEPTH); i++) begin
        msg_q[i] <= BLANK;
      end
    end else if (wr_en) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

  assign X    = x_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule
